// File: rtl/write_back.sv
// Writeback stage: selects the load/ALU result, owns the register file (1 write, 2 async reads) and keeps a registered copy of the result for trace.
// Latency: ResultW and both read ports are combinational (0 cycles); register writes and ResultW_reg land on the rising edge (1 cycle).
// Backpressure: none; the MEM/WB register holds the inputs stable and this stage accepts one result every cycle.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   memToRegW             1 selects readDataW, 0 selects ALUOutW
//   RegWriteW, WriteRegW  register-file write enable and destination index
//   readDataW, ALUOutW    candidate writeback values
//   ResultW, ResultW_reg  selected result (combinational) and its registered copy
//   RA1D/RD1D, RA2D/RD2D  decode-stage read ports with write-through bypass
module write_back #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memToRegW,
    input  logic              RegWriteW,
    input  logic [DATA_W-1:0] readDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    output logic [DATA_W-1:0] ResultW,
    output logic [DATA_W-1:0] ResultW_reg,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic              writeEn;

    // The result mux is deliberately outside the reset domain.
    assign ResultW = memToRegW ? readDataW : ALUOutW;

    // Register 0 is never written, so it holds its reset value of zero forever.
    assign writeEn = RegWriteW && (WriteRegW != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
            ResultW_reg <= '0;
        end else begin
            ResultW_reg <= ResultW;
            if (writeEn) begin
                regFile[WriteRegW] <= ResultW;
            end
        end
    end

    // Read ports: zero for r0 or during reset; otherwise the value being
    // written this cycle wins over the stored copy so decode never sees a
    // stale operand for an instruction retiring in the same cycle.
    always_comb begin
        RD1D = '0;
        if (!rst && (RA1D != '0)) begin
            if (RegWriteW && (WriteRegW == RA1D)) begin
                RD1D = ResultW;
            end else begin
                RD1D = regFile[RA1D];
            end
        end
    end

    always_comb begin
        RD2D = '0;
        if (!rst && (RA2D != '0)) begin
            if (RegWriteW && (WriteRegW == RA2D)) begin
                RD2D = ResultW;
            end else begin
                RD2D = regFile[RA2D];
            end
        end
    end

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          memToRegW;
    logic          RegWriteW;
    logic [DW-1:0] readDataW;
    logic [DW-1:0] ALUOutW;
    logic [AW-1:0] WriteRegW;
    logic [DW-1:0] ResultW;
    logic [DW-1:0] ResultW_reg;
    logic [AW-1:0] RA1D;
    logic [AW-1:0] RA2D;
    logic [DW-1:0] RD1D;
    logic [DW-1:0] RD2D;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural register contents and the trace register.
    logic [DW-1:0] refRegs [NR];
    logic [DW-1:0] refResReg;

    write_back #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .memToRegW  (memToRegW),
        .RegWriteW  (RegWriteW),
        .readDataW  (readDataW),
        .ALUOutW    (ALUOutW),
        .WriteRegW  (WriteRegW),
        .ResultW    (ResultW),
        .ResultW_reg(ResultW_reg),
        .RA1D       (RA1D),
        .RA2D       (RA2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] refResult();
        return memToRegW ? readDataW : ALUOutW;
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        if (rst || a == 0) return '0;
        if (RegWriteW && WriteRegW == a) return refResult();
        return refRegs[a];
    endfunction

    task automatic clearRef();
        for (int i = 0; i < NR; i++) refRegs[i] = '0;
        refResReg = '0;
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, ".res"}, ResultW, refResult());
        checkVal({tag, ".rd1"}, RD1D, refRead(RA1D));
        checkVal({tag, ".rd2"}, RD2D, refRead(RA2D));
        checkVal({tag, ".resReg"}, ResultW_reg, refResReg);
    endtask

    // Advance to the next rising edge, apply its effect to the reference, and
    // leave the bench 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            refResReg = refResult();
            if (RegWriteW && WriteRegW != 0) refRegs[WriteRegW] = refResult();
        end
        #1;
    endtask

    task automatic drive(input logic mem, input logic we, input logic [DW-1:0] rd,
                         input logic [DW-1:0] alu, input logic [AW-1:0] wa,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        memToRegW = mem;
        RegWriteW = we;
        readDataW = rd;
        ALUOutW   = alu;
        WriteRegW = wa;
        RA1D      = a1;
        RA2D      = a2;
    endtask

    initial begin
        rst = 1'b1;
        clearRef();
        drive(0, 0, '0, '0, '0, '0, '0);
        #1;
        checkAll("reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkAll("postReset");

        // Mux, ALU path
        drive(0, 0, 32'd1, 32'd3, 5'd0, 5'd0, 5'd0);
        #1;
        checkVal("muxAlu", ResultW, 32'd3);
        tick();
        checkVal("muxAluReg", ResultW_reg, 32'd3);

        // Mux, memory path and same-cycle toggling
        memToRegW = 1'b1;
        #1;
        checkVal("muxMem", ResultW, 32'd1);
        memToRegW = 1'b0;
        #1;
        checkVal("muxToggleAlu", ResultW, 32'd3);
        memToRegW = 1'b1;
        #1;
        checkVal("muxToggleMem", ResultW, 32'd1);

        // Write then read; disabled write leaves reg 6 alone
        drive(0, 1, 32'd1, 32'd3, 5'd5, 5'd0, 5'd0);
        tick();
        drive(0, 0, 32'd0, 32'd9, 5'd6, 5'd5, 5'd6);
        #1;
        checkVal("readR5", RD1D, 32'd3);
        checkVal("readR6pre", RD2D, 32'd0);
        tick();
        checkVal("readR6post", RD2D, 32'd0);

        // Bypass, then register 0 discard
        drive(0, 1, 32'd0, 32'hDEADBEEF, 5'd7, 5'd0, 5'd7);
        #1;
        checkVal("bypassR7", RD2D, 32'hDEADBEEF);
        tick();
        drive(0, 1, 32'd0, 32'h55, 5'd0, 5'd0, 5'd7);
        #1;
        checkVal("r0Pre", RD1D, 32'd0);
        checkVal("r7Stored", RD2D, 32'hDEADBEEF);
        tick();
        checkVal("r0Post", RD1D, 32'd0);
        checkAll("afterR0");

        // Async reset between edges
        drive(0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd7);
        #1;
        checkVal("r5BeforeRst", RD1D, 32'd3);
        #1;
        rst = 1'b1;
        clearRef();
        #1;
        checkVal("rstR5", RD1D, 32'd0);
        checkVal("rstResReg", ResultW_reg, 32'd0);
        drive(0, 1, 32'd0, 32'd4, 5'd5, 5'd5, 5'd7);
        #1;
        checkVal("rstBlocksBypass", RD1D, 32'd0);
        tick();
        checkVal("rstWriteIgnoredResReg", ResultW_reg, 32'd0);
        rst = 1'b0;
        RegWriteW = 1'b0;
        #1;
        checkVal("rstWriteIgnored", RD1D, 32'd0);
        RegWriteW = 1'b1;
        tick();
        RegWriteW = 1'b0;
        #1;
        checkVal("writeAfterRst", RD1D, 32'd4);

        // Dual port, same address, with and without a simultaneous write
        drive(0, 1, 32'd0, 32'd3, 5'd5, 5'd0, 5'd0);
        tick();
        drive(0, 0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5);
        #1;
        checkVal("dualRd1", RD1D, 32'd3);
        checkVal("dualRd2", RD2D, 32'd3);
        drive(1, 1, 32'd8, 32'd0, 5'd5, 5'd5, 5'd5);
        #1;
        checkVal("dualBypassRd1", RD1D, 32'd8);
        checkVal("dualBypassRd2", RD2D, 32'd8);
        tick();
        RegWriteW = 1'b0;
        #1;
        checkVal("dualStoredRd1", RD1D, 32'd8);
        checkVal("dualStoredRd2", RD2D, 32'd8);

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            logic [AW-1:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, wa, a1, a2);
            #1;
            checkAll("rand");
            if ($urandom_range(0, 39) == 0) begin
                #1;
                rst = 1'b1;
                clearRef();
                #1;
                checkAll("randRst");
                rst = 1'b0;
                #1;
            end
            tick();
            checkAll("randEdge");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final (W) stage of the 5-stage pipelined processor.
- Selects the writeback result: memory load data or ALU result.
- Owns the architectural register file: write port driven by this stage, two asynchronous read ports for decode.
- Also provides a registered copy of the result for debug/trace.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register address width (2**ADDR_W registers).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- memToRegW  in  1  1 = result from readDataW; 0 = result from ALUOutW.
- RegWriteW  in  1  register-file write enable.
- readDataW  in  DATA_W  data-memory load value.
- ALUOutW  in  DATA_W  ALU result.
- WriteRegW  in  ADDR_W  destination register index.
- ResultW  out  DATA_W  combinational writeback result.
- ResultW_reg  out  DATA_W  ResultW captured at the clock edge.
- RA1D  in  ADDR_W  read port 1 address.
- RA2D  in  ADDR_W  read port 2 address.
- RD1D  out  DATA_W  read port 1 data.
- RD2D  out  DATA_W  read port 2 data.

Behaviour:
- Result mux:
  - ResultW = memToRegW ? readDataW : ALUOutW.
  - Purely combinational, zero latency; it is not affected by rst.
- Register file:
  - Holds 2**ADDR_W registers of DATA_W bits.
  - On rising clk, when RegWriteW=1 and WriteRegW!=0, reg[WriteRegW] <= ResultW.
  - Writes to register 0 are discarded; reg 0 always reads 0.
  - RegWriteW=0: no register changes, regardless of the other inputs.
- Read ports:
  - Combinational.
  - RDnD = 0 if RAnD==0.
  - Otherwise, write-through bypass: if RegWriteW=1 and WriteRegW==RAnD, RDnD = ResultW (the same-cycle write is visible before the edge).
  - Otherwise RDnD = reg[RAnD].
  - Both ports may address the same register; both return the same value.
- ResultW_reg:
  - On each rising clk, ResultW_reg <= ResultW.
  - Updates every cycle, independent of RegWriteW.
- Reset:
  - rst=1 immediately (asynchronously) clears all registers and ResultW_reg to 0.
  - While rst=1, writes are blocked and read ports return 0.
  - Deassertion takes effect at the next rising edge; the first write occurs on the first edge with rst=0.
  - Reset asserted mid-operation discards any write pending on that edge.
- Widths: no arithmetic in this block; all values pass through unmodified with no sign or zero extension.
- Inputs are held stable by the preceding MEM/WB pipeline register. There is no handshake and no stall input: one result per cycle.

Test Plan:
1. Mux, ALU path: memToRegW=0, ALUOutW=3, readDataW=1 -> ResultW=3 immediately; ResultW_reg=3 after the next edge.
2. Mux, memory path: memToRegW=1, ALUOutW=3, readDataW=1 -> ResultW=1; toggling memToRegW switches ResultW between 1 and 3 within the same cycle.
3. Write then read: RegWriteW=1, WriteRegW=5, memToRegW=0, ALUOutW=3, edge; then RegWriteW=0, RA1D=5 -> RD1D=3. RegWriteW=0 with WriteRegW=6, ALUOutW=9, edge -> reg 6 stays 0.
4. Bypass and register 0:
   - RegWriteW=1, WriteRegW=7, ALUOutW=0xDEADBEEF, RA2D=7, before the edge -> RD2D=0xDEADBEEF.
   - WriteRegW=0, ALUOutW=0x55 -> RA1D=0 reads 0 before and after the edge.
5. Async reset mid-operation:
   - After reg 5=3, assert rst between edges -> RD1D(RA1D=5)=0 and ResultW_reg=0 without waiting for a clock edge.
   - Write attempted during rst is ignored.
   - After release, a write to reg 5 of 4 reads back 4.
6. Dual-port same address: RA1D=RA2D=5 holding 3 -> RD1D=RD2D=3; with a simultaneous write of 8 to reg 5 -> both read 8 before the edge.
